// File: rtl/aemb_dwb_ctrl_if.sv
// Wishbone classic data-bus bundle between the AEMB data controller and its slave.
interface aemb_dwb_ctrl_if #(
  parameter int DW = 32
);
  logic [DW-1:2] dwb_adr_o;
  logic [3:0]    dwb_sel_o;
  logic [31:0]   dwb_dat_o;
  logic          dwb_stb_o;
  logic          dwb_we_o;
  logic          dwb_ack_i;
  logic [31:0]   dwb_dat_i;

  modport master (
    output dwb_adr_o, dwb_sel_o, dwb_dat_o, dwb_stb_o, dwb_we_o,
    input  dwb_ack_i, dwb_dat_i
  );

  modport slave (
    input  dwb_adr_o, dwb_sel_o, dwb_dat_o, dwb_stb_o, dwb_we_o,
    output dwb_ack_i, dwb_dat_i
  );
endinterface

// File: rtl/aemb_dwb_ctrl.sv
// AEMB data-bus controller: one Wishbone classic cycle per load/store, big-endian
// lane select, store replication, load alignment, stall via gena and bus timeout.
//
// state | meaning
// IDLE  | waiting for a request from execute
// BUS   | strobe asserted, waiting for ack or timeout
// DONE  | access finished, pipeline released for one cycle
module aemb_dwb_ctrl #(
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic              gclk,
  input  logic              grst,
  input  logic              iREQ,
  input  logic              iWE,
  input  logic [1:0]        iSIZ,
  input  logic [31:0]       iADR,
  input  logic [31:0]       iDAT,
  aemb_dwb_ctrl_if.master   dwb,
  output logic              gena,
  output logic [31:0]       rDWBDI,
  output logic              rDWBERR,
  output logic              rMISA
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  localparam logic [7:0] TMO_C  = 8'(TMO);
  localparam bit         TMO_EN = (TMO != 0);

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [DW-1:2] adr_q, adr_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   dat_q, dat_d;
  logic          we_q, we_d;
  logic          stb_q, stb_d;
  logic          misa_pend_q, misa_pend_d;
  logic [31:0]   di_q, di_d;
  logic          err_q, err_d;
  logic          misa_q, misa_d;

  logic [3:0]    req_sel;
  logic [31:0]   req_dat;
  logic          req_misa;
  logic [31:0]   ld_data;

  // Decode the incoming request into lane select, replicated data and misalignment.
  always_comb begin
    req_sel  = 4'hF;
    req_dat  = iDAT;
    req_misa = |iADR[1:0];
    case (iSIZ)
      2'b00: begin
        req_sel  = 4'b1000 >> iADR[1:0];
        req_dat  = {4{iDAT[7:0]}};
        req_misa = 1'b0;
      end
      2'b01: begin
        req_sel  = iADR[1] ? 4'h3 : 4'hC;
        req_dat  = {2{iDAT[15:0]}};
        req_misa = iADR[0];
      end
      default: ;
    endcase
  end

  // Right-justify and zero-extend read data according to the latched lane select.
  always_comb begin
    ld_data = dwb.dwb_dat_i;
    case (sel_q)
      4'b1000: ld_data = {24'd0, dwb.dwb_dat_i[31:24]};
      4'b0100: ld_data = {24'd0, dwb.dwb_dat_i[23:16]};
      4'b0010: ld_data = {24'd0, dwb.dwb_dat_i[15:8]};
      4'b0001: ld_data = {24'd0, dwb.dwb_dat_i[7:0]};
      4'b1100: ld_data = {16'd0, dwb.dwb_dat_i[31:16]};
      4'b0011: ld_data = {16'd0, dwb.dwb_dat_i[15:0]};
      default: ld_data = dwb.dwb_dat_i;
    endcase
  end

  // Next-state and registered-output logic; ack wins over timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    we_d        = we_q;
    stb_d       = stb_q;
    misa_pend_d = misa_pend_q;
    di_d        = di_q;
    err_d       = 1'b0;
    misa_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iREQ) begin
          state_d     = S_BUS;
          adr_d       = iADR[DW-1:2];
          sel_d       = req_sel;
          dat_d       = req_dat;
          we_d        = iWE;
          stb_d       = 1'b1;
          cnt_d       = 8'd0;
          misa_pend_d = req_misa;
        end
      end
      S_BUS: begin
        if (dwb.dwb_ack_i) begin
          state_d = S_DONE;
          stb_d   = 1'b0;
          misa_d  = misa_pend_q;
          if (!we_q) di_d = ld_data;
        end else if (TMO_EN && (cnt_q == TMO_C)) begin
          state_d = S_DONE;
          stb_d   = 1'b0;
          err_d   = 1'b1;
          misa_d  = misa_pend_q;
          if (!we_q) di_d = 32'd0;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        stb_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge gclk) begin
    if (grst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      adr_q       <= '0;
      sel_q       <= 4'd0;
      dat_q       <= 32'd0;
      we_q        <= 1'b0;
      stb_q       <= 1'b0;
      misa_pend_q <= 1'b0;
      di_q        <= 32'd0;
      err_q       <= 1'b0;
      misa_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      stb_q       <= stb_d;
      misa_pend_q <= misa_pend_d;
      di_q        <= di_d;
      err_q       <= err_d;
      misa_q      <= misa_d;
    end
  end

  assign dwb.dwb_adr_o = adr_q;
  assign dwb.dwb_sel_o = sel_q;
  assign dwb.dwb_dat_o = dat_q;
  assign dwb.dwb_stb_o = stb_q;
  assign dwb.dwb_we_o  = we_q;
  assign rDWBDI        = di_q;
  assign rDWBERR       = err_q;
  assign rMISA         = misa_q;
  assign gena          = !grst && (((state_q == S_IDLE) && !iREQ) || (state_q == S_DONE));

endmodule

// File: tb/tb_aemb_dwb_ctrl.sv
// Directed bench for aemb_dwb_ctrl with a hand-driven Wishbone slave.
module tb_aemb_dwb_ctrl;
  logic        gclk;
  logic        grst;
  logic        iREQ;
  logic        iWE;
  logic [1:0]  iSIZ;
  logic [31:0] iADR;
  logic [31:0] iDAT;
  logic        gena;
  logic [31:0] rDWBDI;
  logic        rDWBERR;
  logic        rMISA;

  int n_pass  = 0;
  int n_total = 0;

  aemb_dwb_ctrl_if #(.DW(32)) dwb_bus ();

  aemb_dwb_ctrl #(.DW(32), .TMO(4)) dut (
    .gclk    (gclk),
    .grst    (grst),
    .iREQ    (iREQ),
    .iWE     (iWE),
    .iSIZ    (iSIZ),
    .iADR    (iADR),
    .iDAT    (iDAT),
    .dwb     (dwb_bus.master),
    .gena    (gena),
    .rDWBDI  (rDWBDI),
    .rDWBERR (rDWBERR),
    .rMISA   (rMISA)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  // One access from IDLE; called just after a rising edge.
  // wait_n < 0 means the slave never acks.
  task automatic access(input logic we, input logic [1:0] siz, input logic [31:0] adr,
                        input logic [31:0] dat, input int wait_n, input logic [31:0] rd,
                        output int bus_n, output logic [3:0] sel_s, output logic [31:0] dato_s,
                        output logic [29:0] adr_s, output logic we_s, output logic stable_s,
                        output logic err_s, output logic misa_s, output logic [31:0] di_s,
                        output logic [2:0] gena_s);
    iREQ = 1'b1;
    iWE  = we;
    iSIZ = siz;
    iADR = adr;
    iDAT = dat;
    dwb_bus.dwb_dat_i = rd;
    stable_s = 1'b1;
    sel_s = 4'd0; dato_s = 32'd0; adr_s = 30'd0; we_s = 1'b0;
    @(negedge gclk);
    gena_s[0] = gena;
    @(posedge gclk); #1;
    iREQ  = 1'b0;
    bus_n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge gclk);
      if (!dwb_bus.dwb_stb_o) break;
      if (bus_n == 0) begin
        sel_s = dwb_bus.dwb_sel_o; dato_s = dwb_bus.dwb_dat_o;
        adr_s = dwb_bus.dwb_adr_o; we_s = dwb_bus.dwb_we_o;
        gena_s[1] = gena;
      end else if (sel_s !== dwb_bus.dwb_sel_o || dato_s !== dwb_bus.dwb_dat_o ||
                   adr_s !== dwb_bus.dwb_adr_o || we_s !== dwb_bus.dwb_we_o || gena !== 1'b0) begin
        stable_s = 1'b0;
      end
      bus_n++;
      dwb_bus.dwb_ack_i = (wait_n >= 0) && (bus_n == wait_n + 1);
      @(posedge gclk); #1;
      dwb_bus.dwb_ack_i = 1'b0;
    end
    err_s     = rDWBERR;
    misa_s    = rMISA;
    di_s      = rDWBDI;
    gena_s[2] = gena;
    @(posedge gclk); #1;
  endtask

  task automatic test_reset();
    @(negedge gclk);
    n_total++; if (dwb_bus.dwb_stb_o !== 1'b0) $display("FAIL rst_stb got %0b want 0", dwb_bus.dwb_stb_o); else n_pass++;
    n_total++; if (dwb_bus.dwb_we_o !== 1'b0) $display("FAIL rst_we got %0b want 0", dwb_bus.dwb_we_o); else n_pass++;
    n_total++; if (dwb_bus.dwb_sel_o !== 4'h0) $display("FAIL rst_sel got %h want 0", dwb_bus.dwb_sel_o); else n_pass++;
    n_total++; if (dwb_bus.dwb_adr_o !== 30'h0) $display("FAIL rst_adr got %h want 0", dwb_bus.dwb_adr_o); else n_pass++;
    n_total++; if (dwb_bus.dwb_dat_o !== 32'h0) $display("FAIL rst_dat got %h want 0", dwb_bus.dwb_dat_o); else n_pass++;
    n_total++; if (rDWBDI !== 32'h0) $display("FAIL rst_di got %h want 0", rDWBDI); else n_pass++;
    n_total++; if (rDWBERR !== 1'b0) $display("FAIL rst_err got %0b want 0", rDWBERR); else n_pass++;
    n_total++; if (rMISA !== 1'b0) $display("FAIL rst_misa got %0b want 0", rMISA); else n_pass++;
    n_total++; if (gena !== 1'b0) $display("FAIL rst_gena got %0b want 0", gena); else n_pass++;
    @(posedge gclk); #1;
    grst = 1'b0;
    @(negedge gclk);
    n_total++; if (gena !== 1'b1) $display("FAIL idle_gena got %0b want 1", gena); else n_pass++;
    @(posedge gclk); #1;
  endtask

  task automatic test_byte_load();
    int n; logic [3:0] s; logic [31:0] d, di; logic [29:0] a; logic w, st, e, m; logic [2:0] g;
    access(1'b0, 2'b00, 32'h0000_1002, 32'h0, 0, 32'h1122_3344, n, s, d, a, w, st, e, m, di, g);
    n_total++; if (s !== 4'h2) $display("FAIL bl_sel got %h want 2", s); else n_pass++;
    n_total++; if (a !== 30'h400) $display("FAIL bl_adr got %h want 400", a); else n_pass++;
    n_total++; if (w !== 1'b0) $display("FAIL bl_we got %0b want 0", w); else n_pass++;
    n_total++; if (di !== 32'h0000_0033) $display("FAIL bl_di got %h want 00000033", di); else n_pass++;
    n_total++; if (g !== 3'b100) $display("FAIL bl_gena got %b want 100 (cyc2..0)", g); else n_pass++;
    n_total++; if (n !== 1) $display("FAIL bl_buslen got %0d want 1", n); else n_pass++;
    n_total++; if (e !== 1'b0 || m !== 1'b0) $display("FAIL bl_flags got err=%0b misa=%0b want 0 0", e, m); else n_pass++;
    n_total++; if (dwb_bus.dwb_stb_o !== 1'b0 || gena !== 1'b1) $display("FAIL bl_idle got stb=%0b gena=%0b want 0 1", dwb_bus.dwb_stb_o, gena); else n_pass++;
  endtask

  task automatic test_half_store();
    int n; logic [3:0] s; logic [31:0] d, di; logic [29:0] a; logic w, st, e, m; logic [2:0] g;
    access(1'b1, 2'b01, 32'h0000_0006, 32'hDEAD_BEEF, 3, 32'h5555_AAAA, n, s, d, a, w, st, e, m, di, g);
    n_total++; if (d !== 32'hBEEF_BEEF) $display("FAIL hs_dat got %h want BEEFBEEF", d); else n_pass++;
    n_total++; if (s !== 4'h3) $display("FAIL hs_sel got %h want 3", s); else n_pass++;
    n_total++; if (w !== 1'b1) $display("FAIL hs_we got %0b want 1", w); else n_pass++;
    n_total++; if (n !== 4) $display("FAIL hs_stb_cycles got %0d want 4", n); else n_pass++;
    n_total++; if (st !== 1'b1) $display("FAIL hs_stable got %0b want 1", st); else n_pass++;
    n_total++; if (di !== 32'h0000_0033) $display("FAIL hs_di got %h want 00000033", di); else n_pass++;
    n_total++; if (a !== 30'h1) $display("FAIL hs_adr got %h want 1", a); else n_pass++;
  endtask

  task automatic test_timeout();
    int n; logic [3:0] s; logic [31:0] d, di; logic [29:0] a; logic w, st, e, m; logic [2:0] g;
    access(1'b0, 2'b10, 32'h0000_0100, 32'h0, -1, 32'hFFFF_FFFF, n, s, d, a, w, st, e, m, di, g);
    n_total++; if (n !== 5) $display("FAIL to_buslen got %0d want 5", n); else n_pass++;
    n_total++; if (e !== 1'b1) $display("FAIL to_err got %0b want 1", e); else n_pass++;
    n_total++; if (di !== 32'h0) $display("FAIL to_di got %h want 0", di); else n_pass++;
    n_total++; if (g[2] !== 1'b1) $display("FAIL to_gena_done got %0b want 1", g[2]); else n_pass++;
    n_total++; if (dwb_bus.dwb_stb_o !== 1'b0 || rDWBERR !== 1'b0) $display("FAIL to_idle got stb=%0b err=%0b want 0 0", dwb_bus.dwb_stb_o, rDWBERR); else n_pass++;
  endtask

  task automatic test_misaligned_word();
    int n; logic [3:0] s; logic [31:0] d, di; logic [29:0] a; logic w, st, e, m; logic [2:0] g;
    access(1'b0, 2'b10, 32'h0000_0013, 32'h0, 0, 32'hCAFE_F00D, n, s, d, a, w, st, e, m, di, g);
    n_total++; if (s !== 4'hF) $display("FAIL mw_sel got %h want F", s); else n_pass++;
    n_total++; if (m !== 1'b1) $display("FAIL mw_misa got %0b want 1", m); else n_pass++;
    n_total++; if (di !== 32'hCAFE_F00D) $display("FAIL mw_di got %h want CAFEF00D", di); else n_pass++;
    n_total++; if (e !== 1'b0) $display("FAIL mw_err got %0b want 0", e); else n_pass++;
    n_total++; if (rMISA !== 1'b0) $display("FAIL mw_misa_idle got %0b want 0", rMISA); else n_pass++;
  endtask

  // Directed lane/alignment vectors with read data 0x11223344.
  task automatic test_lanes();
    logic        v_we  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  v_siz [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00};
    logic [31:0] v_adr [6] = '{32'h0, 32'h1, 32'h2, 32'h1, 32'h4, 32'h1};
    logic [3:0]  v_sel [6] = '{4'h8, 4'h4, 4'h3, 4'hC, 4'hF, 4'h4};
    logic [31:0] v_di  [6] = '{32'h11, 32'h22, 32'h3344, 32'h1122, 32'h1122_3344, 32'h1122_3344};
    logic        v_mis [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int n; logic [3:0] s; logic [31:0] d, di; logic [29:0] a; logic w, st, e, m; logic [2:0] g;
    for (int i = 0; i < 6; i++) begin
      access(v_we[i], v_siz[i], v_adr[i], 32'h0000_005A, 0, 32'h1122_3344, n, s, d, a, w, st, e, m, di, g);
      n_total++; if (s !== v_sel[i]) $display("FAIL lane%0d_sel got %h want %h", i, s, v_sel[i]); else n_pass++;
      n_total++; if (di !== v_di[i]) $display("FAIL lane%0d_di got %h want %h", i, di, v_di[i]); else n_pass++;
      n_total++; if (m !== v_mis[i]) $display("FAIL lane%0d_misa got %0b want %0b", i, m, v_mis[i]); else n_pass++;
    end
    n_total++; if (d !== 32'h5A5A_5A5A) $display("FAIL sb_dat got %h want 5A5A5A5A", d); else n_pass++;
  endtask

  task automatic test_reset_mid_bus();
    int n; logic [3:0] s; logic [31:0] d, di; logic [29:0] a; logic w, st, e, m; logic [2:0] g;
    iREQ = 1'b1; iWE = 1'b0; iSIZ = 2'b10; iADR = 32'h0000_0020; dwb_bus.dwb_dat_i = 32'h9999_9999;
    @(posedge gclk); #1;
    iREQ = 1'b0;
    @(posedge gclk); #1;
    grst = 1'b1;
    dwb_bus.dwb_ack_i = 1'b1;
    @(negedge gclk);
    n_total++; if (dwb_bus.dwb_stb_o !== 1'b1 || gena !== 1'b0) $display("FAIL mr_pre got stb=%0b gena=%0b want 1 0", dwb_bus.dwb_stb_o, gena); else n_pass++;
    @(posedge gclk); #1;
    grst = 1'b0;
    dwb_bus.dwb_ack_i = 1'b0;
    @(negedge gclk);
    n_total++; if (dwb_bus.dwb_stb_o !== 1'b0) $display("FAIL mr_stb got %0b want 0", dwb_bus.dwb_stb_o); else n_pass++;
    n_total++; if (dwb_bus.dwb_sel_o !== 4'h0 || dwb_bus.dwb_adr_o !== 30'h0 || dwb_bus.dwb_dat_o !== 32'h0 || dwb_bus.dwb_we_o !== 1'b0)
      $display("FAIL mr_bus got sel=%h adr=%h dat=%h we=%0b want all 0", dwb_bus.dwb_sel_o, dwb_bus.dwb_adr_o, dwb_bus.dwb_dat_o, dwb_bus.dwb_we_o); else n_pass++;
    n_total++; if (rDWBDI !== 32'h0 || rDWBERR !== 1'b0 || rMISA !== 1'b0) $display("FAIL mr_out got di=%h err=%0b misa=%0b want 0 0 0", rDWBDI, rDWBERR, rMISA); else n_pass++;
    n_total++; if (gena !== 1'b1) $display("FAIL mr_gena got %0b want 1", gena); else n_pass++;
    @(posedge gclk); #1;
    n_total++; if (dwb_bus.dwb_stb_o !== 1'b0) $display("FAIL mr_no_done got stb=%0b want 0", dwb_bus.dwb_stb_o); else n_pass++;
    access(1'b0, 2'b00, 32'h0000_0003, 32'h0, 0, 32'h1122_3344, n, s, d, a, w, st, e, m, di, g);
    n_total++; if (s !== 4'h1 || di !== 32'h44 || n !== 1) $display("FAIL mr_after got sel=%h di=%h len=%0d want 1 44 1", s, di, n); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [8:0] stb_seen, gena_seen;
    logic [31:0] di_seen [3];
    iREQ = 1'b1; iWE = 1'b0; iSIZ = 2'b10; iADR = 32'h0000_0040;
    dwb_bus.dwb_ack_i = 1'b1;
    for (int c = 0; c < 9; c++) begin
      dwb_bus.dwb_dat_i = 32'hA000_0000 + 32'(c);
      @(negedge gclk);
      stb_seen[c]  = dwb_bus.dwb_stb_o;
      gena_seen[c] = gena;
      if (c % 3 == 2) di_seen[c / 3] = rDWBDI;
      @(posedge gclk); #1;
    end
    iREQ = 1'b0;
    dwb_bus.dwb_ack_i = 1'b0;
    n_total++; if (stb_seen !== 9'b010_010_010) $display("FAIL b2b_stb got %b want 010010010", stb_seen); else n_pass++;
    n_total++; if (gena_seen !== 9'b100_100_100) $display("FAIL b2b_gena got %b want 100100100", gena_seen); else n_pass++;
    n_total++; if (di_seen[0] !== 32'hA000_0001) $display("FAIL b2b_di0 got %h want A0000001", di_seen[0]); else n_pass++;
    n_total++; if (di_seen[1] !== 32'hA000_0004) $display("FAIL b2b_di1 got %h want A0000004", di_seen[1]); else n_pass++;
    n_total++; if (di_seen[2] !== 32'hA000_0007) $display("FAIL b2b_di2 got %h want A0000007", di_seen[2]); else n_pass++;
    @(negedge gclk);
    n_total++; if (dwb_bus.dwb_stb_o !== 1'b0 || gena !== 1'b1) $display("FAIL b2b_end got stb=%0b gena=%0b want 0 1", dwb_bus.dwb_stb_o, gena); else n_pass++;
    @(posedge gclk); #1;
  endtask

  initial begin
    grst = 1'b1; iREQ = 1'b0; iWE = 1'b0; iSIZ = 2'b00; iADR = 32'h0; iDAT = 32'h0;
    dwb_bus.dwb_ack_i = 1'b0;
    dwb_bus.dwb_dat_i = 32'h0;
    repeat (2) @(posedge gclk);
    #1;
    test_reset();
    test_byte_load();
    test_half_store();
    test_timeout();
    test_misaligned_word();
    test_lanes();
    test_reset_mid_bus();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
